// File: rtl/lsu_apb.sv
// lsu_apb: load/store unit bridging the execute stage to an APB data memory.
//
// One access is in flight at a time. A request accepted in IDLE runs
// through an APB SETUP phase and one or more ACCESS phases. The cycle after
// the slave raises pready, a one-cycle completion pulse reports load data and
// the slave error flag.
//
// Optional feature: define LSU_TIMEOUT_EN to add an access watchdog. It
// aborts an access that waits TIMEOUT ACCESS cycles and reports it as an
// errored completion.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake from the execute stage
//   req_write           1 = store, 0 = load
//   req_addr            word address
//   req_wdata           store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          last load data, held until the next load completes
//   resp_err            completion had a slave error or timeout
//   stall               freeze the upstream pipeline (combinational)
//   err_count           saturating count of errored completions
//   paddr/psel/penable/pwrite/pwdata  APB master outputs
//   prdata/pready/pslverr             APB slave returns
module lsu_apb #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              stall,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("lsu_apb: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t              state_q;
   logic                psel_q;
   logic                penable_q;
   logic                pwrite_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic [7:0]          err_cnt_q;
   logic [7:0]          err_cnt_d;

`ifdef LSU_TIMEOUT_EN
   // Counts ACCESS cycles already spent waiting; the access that would be
   // the TIMEOUT-th without pready is aborted at its closing edge.
   localparam int unsigned     WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
   logic [WD_W-1:0]            wd_q;
`endif

   assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         err_cnt_q    <= '0;
`ifdef LSU_TIMEOUT_EN
         wd_q         <= '0;
`endif
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  state_q  <= SETUP;
                  psel_q   <= 1'b1;
                  pwrite_q <= req_write;
                  paddr_q  <= req_addr;
                  pwdata_q <= req_wdata;
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
               wd_q      <= '0;
`endif
            end
            ACCESS: begin
               if (pready) begin
                  state_q      <= IDLE;
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  pwrite_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= pslverr;
                  if (!pwrite_q) begin
                     resp_rdata_q <= prdata;
                  end
                  if (pslverr) begin
                     err_cnt_q <= err_cnt_d;
                  end
               end
`ifdef LSU_TIMEOUT_EN
               else if (wd_q == WD_LIMIT) begin
                  // Abort: completes as an error with resp_rdata untouched.
                  state_q      <= IDLE;
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  pwrite_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  err_cnt_q    <= err_cnt_d;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE) & ~rst;
   // With rst low, req_valid & ~req_ready already implies a non-IDLE state;
   // the explicit rst gate keeps stall low throughout reset.
   assign stall      = ~rst & ((state_q != IDLE) | (req_valid & ~req_ready));

   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_lsu_apb.sv
// Testbench for lsu_apb: randomized requests, an APB slave model with a
// private memory, and a scoreboard comparing each completion against a
// transaction-level reference (memory array, last load value, error count,
// expected completion cycle).
module tb_lsu_apb;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;
   logic          stall;
   logic [7:0]    err_count;
   logic [AW-1:0] paddr;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata = '0;
   logic          pready = 1'b0;
   logic          pslverr = 1'b0;

   lsu_apb #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .stall(stall), .err_count(err_count),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            waits;
      logic          err;
      logic [DW-1:0] err_rdata;
   } plan_t;

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
      logic [7:0]    errcnt;
      int            cyc;
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];

   logic [DW-1:0] model_mem [64];
   logic [DW-1:0] slave_mem [64];
   logic [DW-1:0] model_rdata = '0;
   int            model_errcnt = 0;
   int            busy_from = 1;
   int            busy_until = 0;
   int            pen_from = 0;
   bit            chk_en = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference: works out the outcome of one op from the access rules and
   // pushes the slave plan and the expected completion.
   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int waits, input logic err, input bit track);
      plan_t p;
      exp_t  e;
      int    acc;
      bit    to;
      to = 1'b0;
`ifdef LSU_TIMEOUT_EN
      to = (waits >= TO);
`endif
      acc         = to ? TO : waits + 1;
      p.wr        = wr;
      p.addr      = addr;
      p.wdata     = wd;
      p.waits     = waits;
      p.err       = err;
      p.err_rdata = DW'($urandom);
      e.cyc       = cyc + 2 + acc;
      if (to) begin
         e.err = 1'b1;
      end else begin
         e.err = err;
         if (!wr) model_rdata = err ? p.err_rdata : model_mem[addr];
         else if (!err) model_mem[addr] = wd;
      end
      e.rdata = model_rdata;
      if (e.err && model_errcnt < 255) model_errcnt++;
      e.errcnt   = 8'(model_errcnt);
      busy_from  = cyc + 1;
      busy_until = e.cyc - 1;
      pen_from   = cyc + 2;
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wd;
      plan_q.push_back(p);
      if (track) exp_q.push_back(e);
   endtask

   task automatic do_op(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int waits, input logic err);
      @(negedge clk);
      while (cyc <= busy_until) begin
         req_valid = 1'b0;
         @(negedge clk);
      end
      issue(wr, addr, wd, waits, err, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Issues whenever the reference says the unit is free (back-to-back
   // allowed); while busy it drives junk requests that must be ignored.
   task automatic run_ops(input int n, input bit force_err);
      int done;
      int w;
      done = 0;
      while (done < n) begin
         @(negedge clk);
         if (cyc > busy_until) begin
            if (force_err) begin
               issue(1'b0, AW'($urandom), DW'($urandom), 0, 1'b1, 1'b1);
               done++;
            end else if ($urandom_range(0, 3) != 0) begin
               w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, TO - 1))
                                               : int'($urandom_range(0, 3));
               issue(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), w,
                     1'($urandom_range(0, 3) == 0), 1'b1);
               done++;
            end else begin
               req_valid = 1'b0;
            end
         end else begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
         end
      end
   endtask

   task automatic drain();
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard monitor plus per-cycle protocol timeline.
   exp_t mon_e;
   bit   mon_busy;
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'(resp_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_err", 32'(resp_err), 32'(mon_e.err));
            chk("resp_rdata", 32'(resp_rdata), 32'(mon_e.rdata));
            chk("err_count", 32'(err_count), 32'(mon_e.errcnt));
            chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
      if (chk_en) begin
         mon_busy = (cyc >= busy_from) && (cyc <= busy_until);
         chk("stall", 32'(stall), 32'(mon_busy));
         chk("req_ready", 32'(req_ready), 32'(!mon_busy));
         chk("psel", 32'(psel), 32'(mon_busy));
         chk("penable", 32'(penable), 32'(mon_busy && cyc >= pen_from));
         if (!mon_busy) chk("pwrite_idle", 32'(pwrite), 32'd0);
      end
   end

   // APB slave: plan taken at SETUP, wait states and error from the plan,
   // random junk on its outputs whenever they must be ignored.
   plan_t cur;
   bit    have = 1'b0;
   int    wcnt = 0;
   always @(negedge clk) begin
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = DW'($urandom);
      if (!rst && psel && !penable) begin
         if (plan_q.size() != 0) begin
            cur  = plan_q.pop_front();
            have = 1'b1;
            wcnt = cur.waits;
         end else begin
            have = 1'b0;
         end
      end
      if (!rst && psel && penable && have) begin
         chk("paddr", 32'(paddr), 32'(cur.addr));
         chk("pwrite", 32'(pwrite), 32'(cur.wr));
         if (cur.wr) chk("pwdata", 32'(pwdata), 32'(cur.wdata));
         if (wcnt > 0) begin
            pready = 1'b0;
            wcnt--;
         end else begin
            pready  = 1'b1;
            pslverr = cur.err;
            if (!cur.wr) prdata = cur.err ? cur.err_rdata : slave_mem[paddr];
            else if (!cur.err) slave_mem[paddr] = pwdata;
            have = 1'b0;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "simulation time limit");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         model_mem[i] = DW'(i * 16'h0101) ^ 16'h5A5A;
         slave_mem[i] = DW'(i * 16'h0101) ^ 16'h5A5A;
      end
      model_mem[5] = 16'h1234;
      slave_mem[5] = 16'h1234;

      // Reset values, with junk on the request port.
      req_valid = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_pwrite", 32'(pwrite), 32'd0);
      chk("rst_paddr", 32'(paddr), 32'd0);
      chk("rst_pwdata", 32'(pwdata), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;

      // Directed cases.
      do_op(1'b0, 6'h05, 16'h0000, 0, 1'b0);
      do_op(1'b1, 6'h3F, 16'hBEEF, 3, 1'b0);
      do_op(1'b0, 6'h3F, 16'h0000, 0, 1'b0);
      do_op(1'b0, 6'h0A, 16'h0000, 1, 1'b1);
      do_op(1'b0, 6'h07, 16'h0000, TO - 1, 1'b0);
      drain();

      // Random traffic, then error saturation with back-to-back loads.
      run_ops(150, 1'b0);
      drain();
      run_ops(300, 1'b1);
      drain();
      chk("err_saturated", 32'(err_count), 32'(model_errcnt));

      // Reset in the middle of an ACCESS wait.
      @(negedge clk);
      while (cyc <= busy_until) @(negedge clk);
      chk_en = 1'b0;
      issue(1'b0, 6'h2A, 16'h0000, 10, 1'b0, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_psel", 32'(psel), 32'd1);
      chk("mid_penable", 32'(penable), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_psel", 32'(psel), 32'd0);
      chk("mid_rst_penable", 32'(penable), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      chk("post_rst_err_count", 32'(err_count), 32'd0);
      chk("post_rst_resp_rdata", 32'(resp_rdata), 32'd0);
      chk("post_rst_paddr", 32'(paddr), 32'd0);
      repeat (5) @(negedge clk);
      model_rdata  = '0;
      model_errcnt = 0;
      busy_from    = 1;
      busy_until   = 0;
      chk_en       = 1'b1;

      run_ops(10, 1'b0);
`ifdef LSU_TIMEOUT_EN
      do_op(1'b0, 6'h11, 16'h0000, 40, 1'b0);
      do_op(1'b1, 6'h12, 16'hCAFE, TO - 1, 1'b0);
      do_op(1'b0, 6'h12, 16'h0000, 0, 1'b0);
`endif
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
